// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a small input FIFO.
// Words are queued on tx_start and serialised LSB first on tx_pin.
// Each frame is: start bit, DATA_BITS data bits, an optional parity bit, then 1 or 2 stop bits.
// When a word is waiting at the end of a stop bit, the next start bit
// follows immediately, so queued frames go out back-to-back.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 2,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] byte2send,
    input  logic                 tx_start,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_pin
);

    // A one-cycle bit still needs a one-bit counter so the vectors stay legal.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PEN   = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);
    localparam logic          ODD       = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wrPtr_q;
    logic [AW-1:0]        rdPtr_q;
    logic [AW:0]          count_q;

    // Transmitter state
    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bitIdx_q;
    logic                 stopIdx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 pin_q;
    logic                 done_q;

    logic                 fifoEmpty;
    logic                 pushEn;
    logic                 popEn;
    logic                 bitEnd;
    logic                 lastStop;
    logic                 dataDone;
    logic                 toStop;
    logic                 doneNext;
    logic [DATA_BITS-1:0] headWord;

    assign fifoEmpty = (count_q == '0);
    assign tx_ready  = (count_q != FULL);
    assign pushEn    = tx_start && tx_ready;
    assign headWord  = mem_q[rdPtr_q];

    assign bitEnd    = (cnt_q == CNT_LAST);
    assign lastStop  = (state_q == S_STOP) && bitEnd && (stopIdx_q == STOP_LAST);
    assign popEn     = !fifoEmpty && ((state_q == S_IDLE) || lastStop);

    assign dataDone  = (state_q == S_DATA) && bitEnd && (bitIdx_q == BIT_LAST);
    assign toStop    = (dataDone && (PARITY == 0)) || ((state_q == S_PARITY) && bitEnd);

    // tx_done is registered, so it is raised on the edge that enters the
    // final cycle of the final stop bit; the three terms cover a multi-cycle
    // stop bit, a one-cycle second stop bit, and a one-cycle single stop bit.
    assign doneNext  = ((state_q == S_STOP) && !bitEnd && (cnt_q == CNT_PEN) &&
                        (stopIdx_q == STOP_LAST))
                     || ((CLKS_PER_BIT == 1) && (STOP_BITS == 2) &&
                         (state_q == S_STOP) && bitEnd && !stopIdx_q)
                     || ((CLKS_PER_BIT == 1) && (STOP_BITS == 1) && toStop);

    assign tx_busy   = (state_q != S_IDLE) || !fifoEmpty;
    assign tx_done   = done_q;
    assign tx_pin    = pin_q;

    // FIFO storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= byte2send;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushEn) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (pushEn && !popEn) begin
                count_q <= count_q + 1'b1;
            end else if (!pushEn && popEn) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Frame sequencer; tx_pin is set on the edge that enters each new bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bitIdx_q  <= '0;
            stopIdx_q <= 1'b0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            pin_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= doneNext;
            if (popEn) begin
                shift_q  <= headWord;
                parity_q <= (^headWord) ^ ODD;
            end
            case (state_q)
                S_IDLE: begin
                    if (popEn) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        pin_q   <= 1'b0;
                    end else begin
                        pin_q   <= 1'b1;
                    end
                end
                S_START: begin
                    if (bitEnd) begin
                        state_q  <= S_DATA;
                        cnt_q    <= '0;
                        bitIdx_q <= '0;
                        pin_q    <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bitEnd) begin
                        cnt_q <= '0;
                        if (bitIdx_q == BIT_LAST) begin
                            if (PARITY != 0) begin
                                state_q <= S_PARITY;
                                pin_q   <= parity_q;
                            end else begin
                                state_q   <= S_STOP;
                                stopIdx_q <= 1'b0;
                                pin_q     <= 1'b1;
                            end
                        end else begin
                            bitIdx_q <= bitIdx_q + 1'b1;
                            shift_q  <= shift_q >> 1;
                            pin_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bitEnd) begin
                        state_q   <= S_STOP;
                        cnt_q     <= '0;
                        stopIdx_q <= 1'b0;
                        pin_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bitEnd) begin
                        cnt_q <= '0;
                        if (stopIdx_q == STOP_LAST) begin
                            if (popEn) begin
                                state_q <= S_START;
                                pin_q   <= 1'b0;
                            end else begin
                                state_q <= S_IDLE;
                                pin_q   <= 1'b1;
                            end
                        end else begin
                            stopIdx_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    pin_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule
